// File: rtl/fifo_word_unpacker_pkg.sv
// Purpose : shared types and helpers for the FIFO word unpacker (state enum,
//           lane-count helpers, lane slicing function).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package fifo_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Widest word the slicing helper accepts; callers zero-extend into it.
  localparam int MAX_W = 512;

  // Default geometry: 32-bit words split into 8-bit beats.
  localparam int DEF_LANES = 32 / 8;

  function automatic int lanes_of(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  // Lane index width, never below 1 so a single-lane build still has a counter.
  function automatic int lane_w_of(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Returns the word shifted so the requested lane sits in the low bits.
  // With msb_first the lane order is mirrored (lane 0 = top slice).
  function automatic logic [MAX_W-1:0] lane_slice(input logic [MAX_W-1:0] word,
                                                  input int              lane,
                                                  input int              lanes,
                                                  input int              out_w,
                                                  input bit              msb_first);
    int idx;
    idx = msb_first ? (lanes - 1 - lane) : lane;
    return word >> (idx * out_w);
  endfunction

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// Purpose : bundles the FIFO read port and the beat output stream of the unpacker.
// Latency : n/a (wiring only).
// Backpressure: n/a (wiring only).
// Ports   : fifo_empty/fifo_rd_rdy/fifo_rd_en/fifo_dout (FIFO read side),
//           m_valid/m_ready/m_data/m_last (beat stream).
//           master = unpacker view, slave = FIFO + downstream view.
interface fifo_word_unpacker_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8
);
  logic              fifo_empty;
  logic              fifo_rd_rdy;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_rd_rdy, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_rdy, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Purpose : pops DATA_W words from the async FIFO read port and emits them as
//           OUT_W beats (m_last on the final beat); optional stats counters
//           behind FIFO_UNPACKER_STATS_EN (word_cnt, beat_cnt).
// Latency : first beat 2 cycles after the pop edge; LANES+2 cycles per word minimum.
// Backpressure: m_ready low holds the current beat; no new pop until the last
//           beat of the word in flight is accepted.
// Ports   : CLK_RD, reset_n (sync, active-low), bus (fifo_word_unpacker_if.master),
//           busy (not IDLE), [word_cnt, beat_cnt when FIFO_UNPACKER_STATS_EN].
module fifo_word_unpacker
  import fifo_unpack_pkg::*;
#(
  parameter int DATA_W    = 32,  // integer multiple of OUT_W
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                   CLK_RD,
  input  logic                   reset_n,
  fifo_word_unpacker_if.master   bus,
  output logic                   busy
`ifdef FIFO_UNPACKER_STATS_EN
  ,
  output logic [15:0]            word_cnt,
  output logic [15:0]            beat_cnt
`endif
);

  localparam int LANES = lanes_of(DATA_W, OUT_W);
  localparam int LW    = lane_w_of(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic [LW-1:0]     lane_q;

  logic              rd_en;
  logic              valid;
  logic              last;
  logic              accept;
  logic [MAX_W-1:0]  slice_full;
  logic              unused_slice;

  assign valid  = (state_q == EMIT);
  assign last   = valid && (lane_q == LAST_LANE);
  assign accept = valid && bus.m_ready;

  assign slice_full   = lane_slice(MAX_W'(hold_q), int'(lane_q), LANES, OUT_W, MSB_FIRST != 0);
  assign unused_slice = ^slice_full[MAX_W-1:OUT_W];

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset_n so no pop is issued while reset is being applied.
        rd_en = reset_n && !bus.fifo_empty;
        if (rd_en && bus.fifo_rd_rdy) state_d = WAIT;
      end
      WAIT: state_d = EMIT;
      EMIT: if (accept && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_RD) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT) begin
        // FIFO read data is valid the cycle after the pop.
        hold_q <= bus.fifo_dout;
        lane_q <= '0;
      end else if (accept && !last) begin
        lane_q <= lane_q + LW'(1);
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_last     = last;
  assign bus.m_data     = valid ? slice_full[OUT_W-1:0] : '0;
  assign busy           = (state_q != IDLE);

`ifdef FIFO_UNPACKER_STATS_EN
  always_ff @(posedge CLK_RD) begin
    if (!reset_n) begin
      word_cnt <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 16'd1;
      if (last) word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule
